// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and PRBS constants for the BIST checker/sender pair
package bist_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} bist_state_e;

  localparam logic [31:0] PRBS_TAPS = 32'h80200003;
  localparam int          PRBS_W    = 32;

endpackage

// File: rtl/bist_prbs_gen.sv
// rtl/bist_prbs_gen.sv - right-shifting Galois LFSR with enable and synchronous reload
module bist_prbs_gen
  import bist_pkg::*;
#(
  parameter logic [PRBS_W-1:0] RESET_SEED = 32'hdeadbeef
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              reload,
  input  logic [PRBS_W-1:0] seed,
  output logic [PRBS_W-1:0] out
);

  logic [PRBS_W-1:0] state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_SEED;
    end else if (reload) begin
      state <= seed;
    end else if (en) begin
      state <= {1'b0, state[PRBS_W-1:1]} ^ (state[0] ? PRBS_TAPS : '0);
    end
  end

  assign out = state;

endmodule

// File: rtl/bist_checker.sv
// rtl/bist_checker.sv - restartable BIST receive checker: regenerates the PRBS stream and
// compares it against the received channels after a latency window.
module bist_checker
  import bist_pkg::*;
#(
  parameter int          TEST_CHANNELS = 70,
  parameter int          RNG_W         = 32,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          SKIP_CYCLES   = 2,
  parameter int          CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop_on_fail,
  input  logic [31:0]              num_cases,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     done,
  output logic                     failed,
  output logic [CNT_W-1:0]         error_count,
  output logic [31:0]              first_fail_idx,
  output logic [TEST_CHANNELS-1:0] fail_mask,
  output logic [TEST_CHANNELS-1:0] output_channels
);

  localparam int          EW        = (TEST_CHANNELS > PRBS_W) ? TEST_CHANNELS : PRBS_W;
  localparam logic [31:0] WARM_LAST = (SKIP_CYCLES > 0) ? 32'(SKIP_CYCLES - 1) : 32'd0;

  bist_state_e              state, state_nx;
  logic [31:0]              ncases, case_idx, warm_cnt;
  logic                     stop_lat;
  logic [TEST_CHANNELS-1:0] expected, expected_nx, diff;
  logic [EW-1:0]            expected_wide;
  logic [PRBS_W-1:0]        prbs_out;
  logic                     launch, advance, mismatch, last_case;

  bist_prbs_gen #(.RESET_SEED(SEED)) u_prbs (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (advance),
    .reload  (launch),
    .seed    (SEED),
    .out     (prbs_out)
  );

  assign diff          = input_channels ^ expected;
  assign mismatch      = |diff;
  assign last_case     = (case_idx == ncases - 32'd1);
  assign expected_wide = (EW'(expected) << RNG_W) | EW'(prbs_out);
  assign expected_nx   = expected_wide[TEST_CHANNELS-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch = 1'b1;
          if (num_cases == 32'd0)   state_nx = DONE;
          else if (SKIP_CYCLES > 0) state_nx = WARMUP;
          else                      state_nx = RUN;
        end
      end
      WARMUP: begin
        if (warm_cnt == WARM_LAST) state_nx = RUN;
      end
      RUN: begin
        advance = 1'b1;
        if (last_case || (mismatch && stop_lat)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ncases         <= '0;
      stop_lat       <= 1'b0;
      expected       <= '0;
      case_idx       <= '0;
      warm_cnt       <= '0;
      failed         <= 1'b0;
      error_count    <= '0;
      first_fail_idx <= '0;
      fail_mask      <= '0;
    end else if (launch) begin
      ncases         <= num_cases;
      stop_lat       <= stop_on_fail;
      expected       <= '0;
      case_idx       <= '0;
      warm_cnt       <= '0;
      failed         <= 1'b0;
      error_count    <= '0;
      first_fail_idx <= '0;
      fail_mask      <= '0;
    end else begin
      if (state == WARMUP) warm_cnt <= warm_cnt + 32'd1;
      if (advance) begin
        expected <= expected_nx;
        case_idx <= case_idx + 32'd1;
        if (mismatch) begin
          failed    <= 1'b1;
          fail_mask <= fail_mask | diff;
          if (error_count != '1) error_count <= error_count + CNT_W'(1);
          if (!failed) first_fail_idx <= case_idx;
        end
      end
    end
  end

  assign busy            = (state == WARMUP) || (state == RUN);
  assign done            = (state == DONE);
  assign output_channels = (done && !failed) ? input_channels : '0;

endmodule

// File: tb/tb_bist_checker.sv
// tb/tb_bist_checker.sv - directed bench for bist_checker; second instance with a 4-bit
// error counter shares all inputs for the saturation case.
module tb_bist_checker;

  localparam int N = 1100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop_on_fail = 1'b0;
  logic [31:0] num_cases = '0;
  logic [69:0] input_channels = '0;

  logic        busy, done, failed;
  logic [15:0] error_count;
  logic [31:0] first_fail_idx;
  logic [69:0] fail_mask, output_channels;

  logic        busy2, done2, failed2;
  logic [3:0]  error_count2;
  logic [31:0] first_fail_idx2;
  logic [69:0] fail_mask2, output_channels2;

  logic [69:0] stream  [0:N-1];
  logic [69:0] corrupt [0:N-1];

  int  checks = 0;
  int  failures = 0;
  int  busy_cycles;
  bit  timed_out;

  always #5 clk = ~clk;

  bist_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop_on_fail(stop_on_fail),
    .num_cases(num_cases), .input_channels(input_channels),
    .busy(busy), .done(done), .failed(failed), .error_count(error_count),
    .first_fail_idx(first_fail_idx), .fail_mask(fail_mask),
    .output_channels(output_channels)
  );

  bist_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .stop_on_fail(stop_on_fail),
    .num_cases(num_cases), .input_channels(input_channels),
    .busy(busy2), .done(done2), .failed(failed2), .error_count(error_count2),
    .first_fail_idx(first_fail_idx2), .fail_mask(fail_mask2),
    .output_channels(output_channels2)
  );

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < N; i++) corrupt[i] = '0;
  endtask

  // Cycle j after the start edge carries case j-2 (two cycles of link latency).
  task automatic run(input int n, input bit stop, input int limit, input int restart_at);
    int cyc;
    @(negedge clk);
    start = 1'b1; num_cases = n; stop_on_fail = stop; input_channels = '0;
    @(negedge clk);
    start = 1'b0; cyc = 0; busy_cycles = 0; timed_out = 1'b0;
    while (busy === 1'b1) begin
      if (cyc >= limit) begin
        timed_out = 1'b1;
        break;
      end
      busy_cycles++;
      start = (cyc == restart_at);
      input_channels = (cyc >= 2 && cyc - 2 < N) ? (stream[cyc-2] ^ corrupt[cyc-2]) : '0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [69:0] e;
    s = 32'hdeadbeef;
    e = '0;
    for (int i = 0; i < N; i++) begin
      stream[i] = e;
      e = {e[37:0], s};
      if (s[0]) s = (s >> 1) ^ 32'h80200003;
      else      s = s >> 1;
    end
    clear_corrupt();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_failed", failed, 0);
    check("rst_err", error_count, 0);
    check("rst_idx", first_fail_idx, 0);
    check("rst_mask", fail_mask, 0);
    check("rst_out", output_channels, 0);
    check("model_case1", stream[1], 70'h00deadbeef);
    reset_n = 1'b1;

    run(1000, 0, 2000, -1);
    check("pass_timeout", timed_out, 0);
    check("pass_busy_cycles", busy_cycles, 1002);
    check("pass_done", done, 1);
    check("pass_failed", failed, 0);
    check("pass_err", error_count, 0);
    input_channels = 70'h2a5555aaaa12345678;
    #1;
    check("pass_mirror", output_channels, 70'h2a5555aaaa12345678);

    run(2, 0, 100, -1);
    check("order_pass_failed", failed, 0);
    corrupt[1] = 70'h8;
    run(2, 0, 100, -1);
    check("order_failed", failed, 1);
    check("order_idx", first_fail_idx, 1);
    check("order_mask", fail_mask, 70'h8);

    for (int r = 0; r < 2; r++) begin
      clear_corrupt();
      corrupt[10] = 70'h1;
      corrupt[20] = 70'h1 << 69;
      corrupt[30] = 70'h1;
      run(100, 0, 500, -1);
      check("cont_busy_cycles", busy_cycles, 102);
      check("cont_done", done, 1);
      check("cont_err", error_count, 3);
      check("cont_idx", first_fail_idx, 10);
      check("cont_mask", fail_mask, (70'h1 << 69) | 70'h1);
      input_channels = 70'h3ffffffffffffffff;
      #1;
      check("cont_out_zero", output_channels, 0);
    end

    clear_corrupt();
    corrupt[5] = 70'h1;
    run(100, 1, 500, -1);
    check("stop_busy_cycles", busy_cycles, 8);
    check("stop_done", done, 1);
    check("stop_err", error_count, 1);
    check("stop_idx", first_fail_idx, 5);

    run(0, 0, 10, -1);
    check("zero_busy_cycles", busy_cycles, 0);
    check("zero_done", done, 1);
    check("zero_failed", failed, 0);
    check("zero_err", error_count, 0);

    clear_corrupt();
    run(50, 0, 500, 20);
    check("restart_busy_cycles", busy_cycles, 52);
    check("restart_failed", failed, 0);

    for (int i = 0; i < 40; i++) corrupt[i] = 70'h1;
    run(40, 0, 500, -1);
    check("sat_err16", error_count, 40);
    check("sat_err4", error_count2, 15);
    check("sat_idx4", first_fail_idx2, 0);
    check("sat_failed4", failed2, 1);

    clear_corrupt();
    corrupt[3] = 70'h1;
    run(100, 0, 20, -1);
    check("abort_busy_before", busy, 1);
    check("abort_failed_before", failed, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_failed", failed, 0);
    check("abort_err", error_count, 0);
    check("abort_idx", first_fail_idx, 0);
    check("abort_mask", fail_mask, 0);
    check("abort_out", output_channels, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_checker.md
Name: bist_checker

Overview:
- Parametrised, restartable BIST receive-side checker for NoC link and router self-test.
- Regenerates the transmitter's PRBS stream locally, widens it to TEST_CHANNELS bits and compares it against the received channels for a runtime-programmable number of cases.
- Skips a configurable pipeline-latency window before comparing, optionally stops on the first failure, and reports error count, first failing case index and a sticky per-lane fail mask.
- Successor to the single-shot fixed-count receiver. Instantiated once per link under test.

Parameters:
- TEST_CHANNELS, 70: number of channels checked.
- RNG_W, 32: PRBS word width shifted into the expected vector per case.
- SEED, 32'hdeadbeef: PRBS reload value; must match the transmitter.
- SKIP_CYCLES, 2: cycles after start during which input is ignored (DUT latency).
- CNT_W, 16: error counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- stop_on_fail  in  1  sampled at start; 1 means end the run on the first mismatch.
- num_cases  in  32  sampled at start; number of compared cases.
- input_channels  in  TEST_CHANNELS  received data.
- busy  out  1  high in WARMUP or RUN.
- done  out  1  high in DONE.
- failed  out  1  sticky; at least one mismatch in the current or last run.
- error_count  out  CNT_W  mismatching cases; saturates at 2^CNT_W-1.
- first_fail_idx  out  32  case index of the first mismatch; 0 if none.
- fail_mask  out  TEST_CHANNELS  sticky OR of (input ^ expected) over all compared cases.
- output_channels  out  TEST_CHANNELS  equals input_channels when done & ~failed, else 0.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE. busy, done, failed = 0. error_count, first_fail_idx, fail_mask = 0. The case counter and expected vector are 0. The PRBS state is SEED. output_channels is 0.
- PRBS: 32-bit Galois LFSR with taps 32'h80200003. Output equals the current state. Advances only when enabled. A synchronous reload sets the state to SEED.
- Expected vector update per advance: expected <= (expected << RNG_W) | zero-extend(prbs_out), truncated to TEST_CHANNELS.
- IDLE or DONE with start=1:
  - latch num_cases and stop_on_fail;
  - clear expected, the case counter and all result outputs;
  - reload the PRBS.
  - Next state: DONE (pass) if num_cases==0; else WARMUP if SKIP_CYCLES>0; else RUN.
- WARMUP: hold the PRBS and expected vector, ignore input. After exactly SKIP_CYCLES cycles go to RUN.
- RUN, each cycle, for case index k:
  - compare input_channels with expected, so case 0 compares against 0;
  - advance the PRBS and expected vector, k <= k+1;
  - on mismatch: failed <= 1, error_count += 1 (saturating), fail_mask |= diff; first_fail_idx <= k only if failed was 0.
  - Exit to DONE when k == num_cases-1 has been compared, or immediately after the first mismatch if stop_on_fail was latched.
- DONE: results held until the next start or reset. output_channels is combinational from state and failed, with no added latency.
- start is ignored while busy.
- A start and mismatch in the same cycle cannot occur: no comparison happens in IDLE or DONE.
- The case counter is 32 bits. num_cases = 2^32-1 is legal and the counter does not wrap.
- Reset asserted mid-run aborts immediately to reset values. No partial results are retained.

Decomposition:
- Package bist_pkg:
  - state enum bist_state_e {IDLE, WARMUP, RUN, DONE};
  - localparam PRBS_TAPS = 32'h80200003;
  - localparam PRBS_W = 32.
- Sub-module bist_prbs_gen (clk, reset_n, en, reload, seed, out): the LFSR with enable and synchronous reload. It is shared with the future bist_sender.

Test Plan:
- Reset and pass: hold reset_n low, then release. Start with num_cases=1000, SKIP_CYCLES=2, and drive the model stream delayed 2 cycles.
  - busy for 1002 cycles, then done=1, failed=0, error_count=0.
  - output_channels mirrors input_channels.
- Stream ordering: drive case 0 = 0 and case 1 = 70'h00deadbeef; the run passes.
  - Flipping bit 3 of case 1 gives failed=1, first_fail_idx=1, fail_mask=70'h8.
- Continue mode: stop_on_fail=0, num_cases=100, corrupt cases 10, 20 and 30 on bits 0, 69 and 0.
  - Run completes 100 cases with error_count=3 and first_fail_idx=10.
  - fail_mask has only bits 0 and 69 set; output_channels=0.
- Stop mode: stop_on_fail=1, corrupt case 5.
  - done asserts the cycle after case 5 is compared; error_count=1; busy was high for exactly 2+6 cycles.
- Edge cases:
  - num_cases=0 gives done the next cycle with failed=0;
  - start while busy has no effect;
  - start in DONE clears results and reruns identically;
  - reset_n pulsed mid-RUN returns all outputs to 0 within the same cycle.
- Saturation: with CNT_W=4, corrupt all of 40 cases; error_count holds at 15 and first_fail_idx=0.
